// File: rtl/ws2812b_receiver_if.sv
// ws2812b_receiver_if: pixel RAM write port and frame status produced by the WS2812B receiver.
interface ws2812b_receiver_if;
    logic [9:0]  ram_addr;
    logic [23:0] ram_data;
    logic        ram_we;
    logic        frame_done;
    logic [9:0]  pixel_count;
    logic        err;
    modport master (output ram_addr, ram_data, ram_we, frame_done, pixel_count, err);
    modport slave  (input  ram_addr, ram_data, ram_we, frame_done, pixel_count, err);
endinterface

// File: rtl/ws2812b_receiver.sv
// ws2812b_receiver: decodes a WS2812B GRB bitstream into 24-bit pixel words written to RAM.
module ws2812b_receiver #(
    parameter int unsigned PIXELS       = 64,
    parameter int unsigned BIT_THRESH   = 12,
    parameter int unsigned MIN_HIGH     = 4,
    parameter int unsigned MAX_HIGH     = 24,
    parameter int unsigned MAX_LOW      = 40,
    parameter int unsigned RESET_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               din_i,
    ws2812b_receiver_if.master bus
);
    localparam logic [10:0] TH    = 11'(BIT_THRESH);
    localparam logic [10:0] MIN_H = 11'(MIN_HIGH);
    localparam logic [10:0] MAX_H = 11'(MAX_HIGH);
    localparam logic [10:0] MAX_L = 11'(MAX_LOW);
    localparam logic [10:0] RST_C = 11'(RESET_CYCLES);
    localparam logic [9:0]  PIX   = 10'(PIXELS);

    typedef enum logic [2:0] {ARM, IDLE, HIGH, LOW, LATCH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [10:0] hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  bit_q, bit_d;
    logic [9:0]  pix_q, pix_d, addr_q, addr_d, pcnt_q, pcnt_d;
    logic [23:0] shift_q, shift_d, data_q, data_d;
    logic        err_q, err_d, we_q, we_d, fd_q, fd_d;
    logic        lvl, rise, fall;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return &v ? v : v + 11'd1;
    endfunction

    // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized level
    assign lvl  = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARM;
            sync_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            pcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], din_i};
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            pcnt_q  <= pcnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            err_q   <= err_d;
            we_q    <= we_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = fall ? 11'd0 : (lvl ? sat_inc(hi_q) : hi_q);
        lo_d    = rise ? 11'd0 : (!lvl ? sat_inc(lo_q) : lo_q);
        bit_d   = bit_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        pcnt_d  = pcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        err_d   = err_q;
        we_d    = 1'b0;
        fd_d    = 1'b0;
        case (state_q)
            ARM: begin
                if (!lvl && lo_q >= RST_C) begin
                    state_d = IDLE;
                    bit_d   = '0;
                    pix_d   = '0;
                end
            end
            IDLE: state_d = rise ? HIGH : IDLE;
            HIGH: begin
                if (hi_q > MAX_H || (fall && hi_q < MIN_H)) begin
                    err_d   = 1'b1;
                    bit_d   = '0;
                    state_d = ARM;
                end else if (fall) begin
                    shift_d = {shift_q[22:0], hi_q >= TH};
                    state_d = LOW;
                    bit_d   = bit_q + 5'd1;
                    // Completed pixel: write it unless the frame is already full
                    if (bit_q == 5'd23) begin
                        bit_d = '0;
                        if (pix_q == PIX) begin
                            err_d = 1'b1;
                        end else begin
                            we_d   = 1'b1;
                            addr_d = pix_q;
                            data_d = shift_d;
                            pix_d  = pix_q + 10'd1;
                        end
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = lo_q <= MAX_L ? HIGH : ARM;
                    err_d   = err_q | (lo_q > MAX_L);
                    bit_d   = lo_q <= MAX_L ? bit_q : 5'd0;
                end else if (lo_q >= RST_C) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                err_d   = err_q | (bit_q != 5'd0);
                fd_d    = pix_q != 10'd0;
                pcnt_d  = pix_q != 10'd0 ? pix_q : pcnt_q;
                pix_d   = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
            default: state_d = ARM;
        endcase
        if (!en_i) begin
            state_d = ARM;
            bit_d   = '0;
            pix_d   = '0;
            err_d   = 1'b0;
            we_d    = 1'b0;
            fd_d    = 1'b0;
        end
    end

    assign bus.ram_addr    = addr_q;
    assign bus.ram_data    = data_q;
    assign bus.ram_we      = we_q;
    assign bus.frame_done  = fd_q;
    assign bus.pixel_count = pcnt_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ws2812b_receiver.sv
// tb_ws2812b_receiver: directed vectors and corner-case sequences for the WS2812B receiver.
module tb_ws2812b_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic din = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   fd_tot = 0;
    logic [9:0]  qa[$];
    logic [23:0] qd[$];

    ws2812b_receiver_if bus();
    ws2812b_receiver dut (.clk(clk), .rst(rst), .en_i(en), .din_i(din), .bus(bus));

    always #25 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we) begin
                qa.push_back(bus.ram_addr);
                qd.push_back(bus.ram_data);
            end
            if (bus.frame_done) fd_tot++;
        end
    end

    typedef struct {
        logic [23:0] word;
        int          hmsb;
        int          nwe;
        logic [23:0] data;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input int idx, input logic [9:0] a, input logic [23:0] d);
        chk({nm, "_addr"}, idx < qa.size() ? 32'(qa[idx]) : 32'hdead, 32'(a));
        chk({nm, "_data"}, idx < qd.size() ? 32'(qd[idx]) : 32'hdead, 32'(d));
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_addr"}, 32'(bus.ram_addr), 0);
        chk({nm, "_data"}, 32'(bus.ram_data), 0);
        chk({nm, "_we"}, 32'(bus.ram_we), 0);
        chk({nm, "_fd"}, 32'(bus.frame_done), 0);
        chk({nm, "_pcnt"}, 32'(bus.pixel_count), 0);
        chk({nm, "_err"}, 32'(bus.err), 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int h, input int l);
        din = 1'b1;
        tick(h);
        din = 1'b0;
        tick(l);
    endtask

    // fast=1 uses short legal timings to keep long frames cheap
    task automatic send_word(input logic [23:0] w, input int hmsb, input bit fast);
        for (int i = 23; i >= 0; i--) begin
            int h, l;
            if (i == 23 && hmsb != 0) begin
                h = hmsb;
                l = (25 - h < 9) ? 9 : 25 - h;
            end else if (fast) begin
                h = w[i] ? 12 : 5;
                l = 5;
            end else begin
                h = w[i] ? 16 : 8;
                l = w[i] ? 9 : 17;
            end
            send_bit(h, l);
        end
    endtask

    task automatic en_pulse();
        en = 1'b0;
        tick(3);
        en = 1'b1;
    endtask

    initial begin
        int base, fb;
        tbl[0] = '{24'hFF0000, 0,  1, 24'hFF0000, 1'b0};
        tbl[1] = '{24'h00A5C3, 0,  1, 24'h00A5C3, 1'b0};
        tbl[2] = '{24'h000000, 0,  1, 24'h000000, 1'b0};
        tbl[3] = '{24'hFFFFFF, 0,  1, 24'hFFFFFF, 1'b0};
        tbl[4] = '{24'h7FFFFF, 11, 1, 24'h7FFFFF, 1'b0};
        tbl[5] = '{24'h000001, 12, 1, 24'h800001, 1'b0};
        tbl[6] = '{24'h0F0F0F, 4,  1, 24'h0F0F0F, 1'b0};
        tbl[7] = '{24'h000000, 24, 1, 24'h800000, 1'b0};
        tbl[8] = '{24'h123456, 3,  0, 24'h000000, 1'b1};
        tbl[9] = '{24'h123456, 25, 0, 24'h000000, 1'b1};

        tick(3);
        chk_idle_outputs("reset");
        rst = 1'b0;

        base = qa.size(); fb = fd_tot;
        tick(1050);
        send_word(24'hFF0000, 0, 0);
        send_word(24'h00A5C3, 0, 0);
        tick(1050);
        chk("pu_nwe", 32'(qa.size() - base), 2);
        chk_wr("pu_w0", base, 10'd0, 24'hFF0000);
        chk_wr("pu_w1", base + 1, 10'd1, 24'h00A5C3);
        chk("pu_fd", 32'(fd_tot - fb), 1);
        chk("pu_pcnt", 32'(bus.pixel_count), 2);
        chk("pu_err", 32'(bus.err), 0);

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        base = qa.size(); fb = fd_tot;
        send_word(24'hABCDEF, 0, 0);
        chk("noarm_nwe0", 32'(qa.size() - base), 0);
        tick(1050);
        chk("noarm_nwe1", 32'(qa.size() - base), 0);
        chk("noarm_fd0", 32'(fd_tot - fb), 0);
        send_word(24'h135790, 0, 0);
        tick(1050);
        chk("noarm_nwe", 32'(qa.size() - base), 1);
        chk_wr("noarm_w0", base, 10'd0, 24'h135790);
        chk("noarm_fd", 32'(fd_tot - fb), 1);
        chk("noarm_pcnt", 32'(bus.pixel_count), 1);
        chk("noarm_err", 32'(bus.err), 0);

        for (int i = 0; i < 10; i++) begin
            en_pulse();
            base = qa.size(); fb = fd_tot;
            tick(1050);
            send_word(tbl[i].word, tbl[i].hmsb, 0);
            tick(1050);
            chk($sformatf("v%0d_nwe", i), 32'(qa.size() - base), 32'(tbl[i].nwe));
            chk($sformatf("v%0d_fd", i), 32'(fd_tot - fb), 32'(tbl[i].nwe));
            chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(tbl[i].err));
            if (tbl[i].nwe > 0) begin
                chk_wr($sformatf("v%0d_w", i), base, 10'd0, tbl[i].data);
                chk($sformatf("v%0d_pcnt", i), 32'(bus.pixel_count), 1);
            end
        end

        en_pulse();
        base = qa.size(); fb = fd_tot;
        tick(1050);
        send_word(24'h123456, 0, 0);
        repeat (6) send_bit(16, 9);
        tick(1050);
        chk("part_nwe", 32'(qa.size() - base), 1);
        chk_wr("part_w0", base, 10'd0, 24'h123456);
        chk("part_fd", 32'(fd_tot - fb), 1);
        chk("part_pcnt", 32'(bus.pixel_count), 1);
        chk("part_err", 32'(bus.err), 1);

        base = qa.size(); fb = fd_tot;
        send_word(24'h111111, 0, 0);
        repeat (12) send_bit(8, 17);
        din = 1'b1;
        tick(5);
        en = 1'b0;
        tick(2);
        din = 1'b0;
        tick(3);
        chk("en_err", 32'(bus.err), 0);
        chk("en_we", 32'(bus.ram_we), 0);
        chk("en_fdo", 32'(bus.frame_done), 0);
        chk("en_pcnt", 32'(bus.pixel_count), 1);
        chk("en_nwe", 32'(qa.size() - base), 1);
        en = 1'b1;
        tick(1050);
        chk("en_fd0", 32'(fd_tot - fb), 0);
        send_word(24'h2468AC, 0, 0);
        tick(1050);
        chk("en_nwe2", 32'(qa.size() - base), 2);
        chk_wr("en_w1", base + 1, 10'd0, 24'h2468AC);
        chk("en_fd", 32'(fd_tot - fb), 1);
        chk("en_pcnt2", 32'(bus.pixel_count), 1);
        chk("en_err2", 32'(bus.err), 0);

        base = qa.size(); fb = fd_tot;
        for (int p = 0; p < 64; p++) begin
            logic [7:0] b;
            b = 8'(p);
            send_word({b, ~b, b ^ 8'h5A}, 0, 1);
        end
        chk("ovf_err_at64", 32'(bus.err), 0);
        for (int p = 64; p < 66; p++) begin
            logic [7:0] b;
            b = 8'(p);
            send_word({b, ~b, b ^ 8'h5A}, 0, 1);
        end
        tick(1050);
        chk("ovf_nwe", 32'(qa.size() - base), 64);
        for (int p = 0; p < 64; p++) begin
            logic [7:0] b;
            b = 8'(p);
            chk_wr($sformatf("ovf_w%0d", p), base + p, 10'(p), {b, ~b, b ^ 8'h5A});
        end
        chk("ovf_fd", 32'(fd_tot - fb), 1);
        chk("ovf_pcnt", 32'(bus.pixel_count), 64);
        chk("ovf_err", 32'(bus.err), 1);

        base = qa.size(); fb = fd_tot;
        repeat (12) send_bit(16, 9);
        din = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(2);
        chk_idle_outputs("rabort");
        din = 1'b0;
        tick(1);
        rst = 1'b0;
        chk("rabort_nwe", 32'(qa.size() - base), 0);
        tick(1050);
        chk("rabort_fd0", 32'(fd_tot - fb), 0);
        send_word(24'h5A5A5A, 0, 0);
        tick(1050);
        chk("rabort_nwe1", 32'(qa.size() - base), 1);
        chk_wr("rabort_w0", base, 10'd0, 24'h5A5A5A);
        chk("rabort_fd", 32'(fd_tot - fb), 1);
        chk("rabort_pcnt", 32'(bus.pixel_count), 1);
        chk("rabort_err", 32'(bus.err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
